// File: rtl/cpu_pkg.sv
// Shared pipeline types for hazard control: scoreboard entry, forward selects, FSM states.
package cpu_pkg;

  localparam logic [4:0] XZR       = 5'd31;
  localparam int         SB_STAGES = 3;   // EX, MEM, WB
  localparam int         NUM_SRC   = 2;   // Rn, Ab

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
    logic       setflags;
  } sb_entry_t;

  // XZR reads are hardwired zero, so they never depend on an older writer
  function automatic logic src_hit(input sb_entry_t e, input logic use_src,
                                   input logic [4:0] src);
    return use_src && e.valid && (e.rd == src) && (src != XZR);
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Three-stage destination scoreboard (EX/MEM/WB) with per-source, per-stage hit vector.
module hz_scoreboard
  import cpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         ins_valid,
  input  logic [4:0]                   ins_rd,
  input  logic                         ins_load,
  input  logic                         ins_setflags,
  input  logic [NUM_SRC*5-1:0]         src_regs,
  input  logic [NUM_SRC-1:0]           src_use,
  output logic [NUM_SRC*SB_STAGES-1:0] hit,
  output logic                         ex_load,
  output logic                         ex_setflags
);

  // index 0 = EX (youngest), SB_STAGES-1 = WB
  sb_entry_t [SB_STAGES-1:0] sb_q;
  sb_entry_t                 ex_d;

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.valid    = ins_valid;
      ex_d.rd       = ins_rd;
      ex_d.load     = ins_load;
      ex_d.setflags = ins_setflags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= {sb_q[SB_STAGES-2:0], ex_d};
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    for (genvar st = 0; st < SB_STAGES; st++) begin : g_stage
      assign hit[s*SB_STAGES+st] = src_hit(sb_q[st], src_use[s], src_regs[s*5 +: 5]);
    end
  end

  assign ex_load     = sb_q[0].valid & sb_q[0].load;
  assign ex_setflags = sb_q[0].setflags;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush FSM, operand forwarding, stall counter.
// Build option: HAZARD_FWD_EN enables EX/MEM forwarding; without it every EX/MEM match stalls.
module hazard_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_Rn,
  input  logic [4:0]  id_Ab,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic [4:0]  id_Rd,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_SetFlags,
  input  logic        id_UseFlags,
  input  logic        id_BrTaken,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_cycles
);

  logic [NUM_SRC*5-1:0]         src_regs;
  logic [NUM_SRC-1:0]           src_use;
  logic [NUM_SRC*SB_STAGES-1:0] hit;
  logic                         ex_load, ex_setflags;
  logic                         hazard, stall;
  hz_state_t                    state;

  assign src_regs = {id_Ab, id_Rn};
  assign src_use  = {id_use_b, id_use_a} & {NUM_SRC{id_valid}};

  hz_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ins_valid    (id_valid & id_RegWrite),
    .ins_rd       (id_Rd),
    .ins_load     (id_valid & id_MemRead),
    .ins_setflags (id_valid & id_SetFlags),
    .src_regs     (src_regs),
    .src_use      (src_use),
    .hit          (hit),
    .ex_load      (ex_load),
    .ex_setflags  (ex_setflags)
  );

`ifndef HAZARD_FWD_EN
  // WB producers are covered by write-before-read in the register file
  localparam logic [SB_STAGES-1:0] NOFWD_STALL_MASK = 3'b011;
`endif

  always_comb begin
    hazard = id_valid & id_UseFlags & ex_setflags;
    for (int s = 0; s < NUM_SRC; s++) begin
      hazard |= hit[s*SB_STAGES] & ex_load;
`ifndef HAZARD_FWD_EN
      hazard |= |(hit[s*SB_STAGES +: SB_STAGES] & NOFWD_STALL_MASK);
`endif
    end
  end

  // the instruction in ID during FLUSH is being squashed; it must not hold the PC
  assign stall         = hazard & (state != FLUSH);
  assign pc_write_en   = ~stall;
  assign ifid_write_en = ~stall;
  assign idex_bubble   = stall;

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_sel [NUM_SRC];

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      casez (hit[s*SB_STAGES +: SB_STAGES] & {{(SB_STAGES-1){1'b1}}, ~ex_load})
        3'b??1:  fwd_sel[s] = FWD_EXMEM;
        3'b?10:  fwd_sel[s] = FWD_MEMWB;
        default: fwd_sel[s] = FWD_RF;
      endcase
    end
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  // a branch held in ID by a stall is re-evaluated on the following cycle,
  // so STALL may chain into another STALL or into FLUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ifid_flush <= 1'b0;
    end else begin
      ifid_flush <= 1'b0;
      case (state)
        RUN, STALL: begin
          if (stall) begin
            state <= STALL;
          end else if (id_valid && id_BrTaken) begin
            state      <= FLUSH;
            ifid_flush <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n;
  logic        id_valid, id_use_a, id_use_b;
  logic [4:0]  id_Rn, id_Ab, id_Rd;
  logic        id_RegWrite, id_MemRead, id_SetFlags, id_UseFlags, id_BrTaken;
  logic        pc_write_en, ifid_write_en, idex_bubble, ifid_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_Rn(id_Rn), .id_Ab(id_Ab),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_SetFlags(id_SetFlags), .id_UseFlags(id_UseFlags),
    .id_BrTaken(id_BrTaken), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {pc_write_en, ifid_write_en, idex_bubble, ifid_flush}
  task automatic chk_ctl(input string tag, input logic stl, input logic fl);
    chk(tag, {28'd0, pc_write_en, ifid_write_en, idex_bubble, ifid_flush},
        {28'd0, ~stl, ~stl, stl, fl});
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] ab,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic sf, input logic uf,
                       input logic br);
    id_valid = v; id_Rn = rn; id_Ab = ab; id_use_a = ua; id_use_b = ub; id_Rd = rd;
    id_RegWrite = rw; id_MemRead = mr; id_SetFlags = sf; id_UseFlags = uf; id_BrTaken = br;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk_ctl("reset_ctl", 0, 0);
    chk("reset_fwd", {30'd0, fwd_a}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // LDUR X3 then ADD X4, X3
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    chk_ctl("ldur_issue", 0, 0);
    tick();
    drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0);
    chk_ctl("lu_stall", 1, 0);
    chk("lu_cnt0", stall_cycles, 32'd0);
    tick();
    chk_ctl("lu_mem", !FWD, 0);
    chk("lu_fwd_a", {30'd0, fwd_a}, FWD ? 32'd2 : 32'd0);
    chk("lu_cnt1", stall_cycles, 32'd1);
    tick();
    chk_ctl("lu_wb", 0, 0);
    chk("lu_cnt2", stall_cycles, FWD ? 32'd1 : 32'd2);
    drain();

    // ADD X5 then consumer on Ab=5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0);
    chk_ctl("alu_ex", !FWD, 0);
    chk("alu_fwd_b_ex", {30'd0, fwd_b}, FWD ? 32'd1 : 32'd0);
    chk("alu_fwd_a_ex", {30'd0, fwd_a}, 32'd0);
    tick();
    chk_ctl("alu_mem", !FWD, 0);
    chk("alu_fwd_b_mem", {30'd0, fwd_b}, FWD ? 32'd2 : 32'd0);
    tick();
    chk_ctl("alu_wb", 0, 0);
    chk("alu_fwd_b_wb", {30'd0, fwd_b}, 32'd0);
    chk("alu_cnt", stall_cycles, FWD ? 32'd1 : 32'd4);
    drain();

    // ADD X31 then read Rn=31
    drive(1, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0);
    tick();
    drive(1, 31, 0, 1, 0, 7, 1, 0, 0, 0, 0);
    chk_ctl("xzr_ex", 0, 0);
    chk("xzr_fwd_a", {30'd0, fwd_a}, 32'd0);
    tick();
    chk_ctl("xzr_mem", 0, 0);
    drain();

    // CMP (flags, no register write) then B.cond
    drive(1, 0, 0, 0, 0, 31, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk_ctl("flag_stall", 1, 0);
    tick();
    chk_ctl("flag_clear", 0, 0);
    chk("flag_cnt", stall_cycles, FWD ? 32'd2 : 32'd5);
    drain();

    // taken branch; a second BrTaken during FLUSH is ignored
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_ctl("br_id", 0, 0);
    tick();
    chk_ctl("br_flush", 0, 1);
    tick();
    chk_ctl("br_run", 0, 0);
    idle();
    tick();
    chk_ctl("br_idle", 0, 0);
    drain();

    // load-use and branch together: stall first, then flush
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    tick();
    drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    chk_ctl("lubr_c1", 1, 0);
    tick();
`ifdef HAZARD_FWD_EN
    chk_ctl("lubr_c2", 0, 0);
    tick();
    idle();
    chk_ctl("lubr_flush", 0, 1);
    tick();
    chk_ctl("lubr_run", 0, 0);
`else
    chk_ctl("lubr_c2", 1, 0);
    tick();
    chk_ctl("lubr_c3", 0, 0);
    tick();
    idle();
    chk_ctl("lubr_flush", 0, 1);
    tick();
    chk_ctl("lubr_run", 0, 0);
`endif
    chk("lubr_cnt", stall_cycles, FWD ? 32'd3 : 32'd7);
    drain();

    // reset pulsed during STALL
    drive(1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0);
    tick();
    drive(1, 9, 9, 1, 1, 0, 0, 0, 0, 1, 0);
    chk_ctl("rst_pre", 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("rst_stall_ctl", 0, 0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_stall_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk_ctl("rst_sb_empty", 0, 0);
    chk("rst_cnt_after", stall_cycles, 32'd0);
    drain();

    // reset pulsed during FLUSH
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    chk_ctl("rstf_pre", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("rstf_ctl", 0, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_ctl("rstf_after", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
